// File: rtl/bus_sequencer.sv
// Command FIFO feeding a one-at-a-time req/ack bus sequencer (write, read, poll, reserved).
// Define BUS_SEQUENCER_POLL_EN to build the poll op (masked compare with bounded retry).
module bus_sequencer #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int POLL_MAX   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [DATA_W-1:0] cmd_mask,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_RSV  = 2'b11;

    typedef struct packed {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
`ifdef BUS_SEQUENCER_POLL_EN
        logic [DATA_W-1:0] mask;
`endif
    } cmd_t;

    typedef enum logic [1:0] {IDLE, REQ, GAP, RSP} state_t;

    cmd_t             mem [FIFO_DEPTH];
    cmd_t             in_cmd, head, cur, cur_nxt;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             full, empty, push, pop, head_bus;
    state_t           state, state_nxt;
    logic [DATA_W-1:0] rsp_data_nxt;
    logic             rsp_err_nxt;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = mem[rd_ptr];

    always_comb begin
        in_cmd       = '0;
        in_cmd.op    = cmd_op;
        in_cmd.addr  = cmd_addr;
        in_cmd.wdata = cmd_wdata;
`ifdef BUS_SEQUENCER_POLL_EN
        in_cmd.mask  = cmd_mask;
`endif
    end

`ifdef BUS_SEQUENCER_POLL_EN
    localparam int CNT_W = $clog2(POLL_MAX + 1);
    logic [CNT_W-1:0] attempts, attempts_nxt;
    logic             poll_hit;

    assign head_bus = (head.op != OP_RSV);
    assign poll_hit = ((bus_rdata & cur.mask) == (cur.wdata & cur.mask));
`else
    // Without the poll feature, op 10 falls into the reserved path.
    logic unused_mask;
    assign unused_mask = ^cmd_mask;
    assign head_bus    = (head.op == OP_WR) || (head.op == OP_RD);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_cmd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cur      <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
`ifdef BUS_SEQUENCER_POLL_EN
            attempts <= '0;
`endif
        end else begin
            state    <= state_nxt;
            cur      <= cur_nxt;
            rsp_data <= rsp_data_nxt;
            rsp_err  <= rsp_err_nxt;
`ifdef BUS_SEQUENCER_POLL_EN
            attempts <= attempts_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        cur_nxt      = cur;
        rsp_data_nxt = rsp_data;
        rsp_err_nxt  = rsp_err;
        pop          = 1'b0;
`ifdef BUS_SEQUENCER_POLL_EN
        attempts_nxt = attempts;
`endif
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop          = 1'b1;
                    cur_nxt      = head;
                    rsp_data_nxt = '0;
                    rsp_err_nxt  = !head_bus;
`ifdef BUS_SEQUENCER_POLL_EN
                    attempts_nxt = '0;
`endif
                    state_nxt    = head_bus ? REQ : RSP;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    rsp_data_nxt = (cur.op == OP_WR) ? '0 : bus_rdata;
                    state_nxt    = RSP;
`ifdef BUS_SEQUENCER_POLL_EN
                    // A missed poll retries after a one-cycle gap until POLL_MAX misses.
                    if (cur.op != OP_WR && cur.op != OP_RD && !poll_hit) begin
                        attempts_nxt = attempts + 1'b1;
                        if (attempts_nxt == CNT_W'(POLL_MAX)) rsp_err_nxt = 1'b1;
                        else                                  state_nxt   = GAP;
                    end
`endif
                end
            end
            GAP:     state_nxt = REQ;
            RSP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus_req   = (state == REQ);
    assign bus_we    = bus_req && (cur.op == OP_WR);
    assign bus_addr  = cur.addr;
    assign bus_wdata = cur.wdata;
    assign rsp_valid = (state == RSP);
    assign busy      = !empty || (state != IDLE);

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: directed vector table, hand-written corner sequences and a
// randomized run checked against a queue-based transaction model.
`timescale 1ns/1ps
module tb_bus_sequencer;
    localparam int AW = 32, DW = 32, DEPTH = 4, PMAX = 16;
`ifdef BUS_SEQUENCER_POLL_EN
    localparam bit POLL_EN = 1'b1;
`else
    localparam bit POLL_EN = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0, cmd_mask = '0;
    logic bus_req, bus_we, bus_ack, rsp_valid, rsp_err, busy;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata, bus_rdata, rsp_data;

    logic auto_bus = 1'b0, auto_ack = 1'b0, man_ack = 1'b0;
    logic [DW-1:0] auto_rdata = '0, man_rdata = '0;
    assign bus_ack   = auto_bus ? auto_ack   : man_ack;
    assign bus_rdata = auto_bus ? auto_rdata : man_rdata;

    bus_sequencer #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .POLL_MAX(PMAX)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy));

    always #5 clk = ~clk;

    typedef struct { logic [1:0] op; logic [AW-1:0] addr; logic [DW-1:0] wdata, mask; } cmd_t;
    typedef struct { logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata, rdata; } bus_t;
    typedef struct { logic [DW-1:0] data; logic err; } rsp_t;
    typedef struct {
        logic [1:0] op; logic [AW-1:0] addr; logic [DW-1:0] wdata, mask, rdata;
        int waits; int exp_reqs; logic [DW-1:0] exp_data; logic exp_err;
    } vec_t;

    cmd_t cmd_q[$];
    bus_t bus_log[$];
    rsp_t rsp_log[$];
    int n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random slave: acks only requests it logs, so the model sees every completed transfer.
    always @(negedge clk) begin
        auto_ack   = auto_bus && ($urandom_range(0, 1) == 1);
        auto_rdata = DW'($urandom_range(0, 3));
        if (auto_bus && bus_req && auto_ack)
            bus_log.push_back('{bus_addr, bus_we, bus_wdata, auto_rdata});
        if (rsp_valid) rsp_log.push_back('{rsp_data, rsp_err});
    end

    task automatic push_cmd(input cmd_t c);
        int guard = 0;
        cmd_valid = 1'b1; cmd_op = c.op; cmd_addr = c.addr; cmd_wdata = c.wdata; cmd_mask = c.mask;
        while (!cmd_ready && guard < 5000) begin tick(); guard++; end
        if (!cmd_ready) begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout: cmd_ready stuck 0");
        end
        tick();
        cmd_valid = 1'b0;
        cmd_q.push_back(c);
    endtask

    task automatic drain();
        int g = 0;
        while (busy && g < 20000) begin tick(); g++; end
        check("drain_busy", 64'(busy), 64'(0));
    endtask

    // Walk the commands in order and consume the bus transfers each one implies.
    task automatic model_check();
        cmd_t c; bus_t b; rsp_t r;
        logic [DW-1:0] ed; logic ee; int n; bit done, bad;
        while (cmd_q.size() > 0) begin
            c = cmd_q.pop_front(); ed = '0; ee = 1'b0; bad = 1'b0;
            if (c.op == 2'd0 || c.op == 2'd1 || (POLL_EN && c.op == 2'd2)) begin
                n = 0; done = 1'b0;
                while (!done) begin
                    if (bus_log.size() == 0) begin bad = 1'b1; done = 1'b1; end
                    else begin
                        b = bus_log.pop_front(); n++;
                        if (b.addr !== c.addr || b.we !== (c.op == 2'd0) ||
                            (c.op == 2'd0 && b.wdata !== c.wdata)) bad = 1'b1;
                        if (c.op == 2'd0) done = 1'b1;
                        else begin
                            ed = b.rdata;
                            if (c.op == 2'd1 || (b.rdata & c.mask) == (c.wdata & c.mask)) done = 1'b1;
                            else if (n == PMAX) begin ee = 1'b1; done = 1'b1; end
                        end
                    end
                end
            end else ee = 1'b1;
            check($sformatf("bus_xfer op%0d @%0h", c.op, c.addr), 64'(bad), 64'(0));
            if (rsp_log.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL rsp_missing: no response for op%0d @%0h", c.op, c.addr);
            end else begin
                r = rsp_log.pop_front();
                check($sformatf("rsp_data op%0d @%0h", c.op, c.addr), 64'(r.data), 64'(ed));
                check($sformatf("rsp_err op%0d @%0h", c.op, c.addr), 64'(r.err), 64'(ee));
            end
        end
        check("bus_extra", 64'(bus_log.size()), 64'(0));
        check("rsp_extra", 64'(rsp_log.size()), 64'(0));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int reqs = 0, wcnt = 0, cyc = 0, first = -1;
        bit got = 1'b0, bad = 1'b0;
        cmd_valid = 1'b1; cmd_op = v.op; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_mask = v.mask;
        tick();
        cmd_valid = 1'b0;
        while (!got && cyc < 200) begin
            if (bus_req) begin
                if (first < 0) first = cyc;
                reqs++;
                if (bus_addr !== v.addr || bus_we !== (v.op == 2'd0) ||
                    (v.op == 2'd0 && bus_wdata !== v.wdata)) bad = 1'b1;
                man_ack = (wcnt == v.waits); man_rdata = v.rdata; wcnt++;
            end else begin
                man_ack = 1'b0; wcnt = 0;
            end
            if (rsp_valid) begin
                got = 1'b1;
                check($sformatf("v%0d rsp_data", idx), 64'(rsp_data), 64'(v.exp_data));
                check($sformatf("v%0d rsp_err", idx), 64'(rsp_err), 64'(v.exp_err));
            end
            tick(); cyc++;
        end
        man_ack = 1'b0;
        check($sformatf("v%0d rsp_seen", idx), 64'(got), 64'(1));
        check($sformatf("v%0d req_cycles", idx), 64'(reqs), 64'(v.exp_reqs));
        check($sformatf("v%0d bus_hold", idx), 64'(bad), 64'(0));
        if (v.exp_reqs > 0) check($sformatf("v%0d first_req", idx), 64'(first), 64'(1));
        check($sformatf("v%0d rsp_one_cycle", idx), 64'(rsp_valid), 64'(0));
        check($sformatf("v%0d idle_busy", idx), 64'(busy), 64'(0));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        cmd_t c;
        logic [7:0] req_hist, rsp_hist;
        logic [DW-1:0] cap_data; logic cap_err;
        bit seen;
        int k;

        vecs[0] = '{2'd0, 32'h0200_0000, 32'h0000_00A5, 32'h0, 32'h0, 0, 1, 32'h0, 1'b0};
        vecs[1] = '{2'd1, 32'h0200_0000, 32'h0, 32'h0, 32'h0000_005A, 3, 4, 32'h5A, 1'b0};
        vecs[2] = '{2'd1, 32'h0000_1004, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFF, 1'b0};
        vecs[3] = '{2'd0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 32'h0, 2, 3, 32'h0, 1'b0};
        vecs[4] = '{2'd3, 32'h0000_0020, 32'h1234, 32'h0, 32'h0, 0, 0, 32'h0, 1'b1};
        if (POLL_EN) begin
            vecs[5] = '{2'd2, 32'h30, 32'h1, 32'h1, 32'h3, 1, 2, 32'h3, 1'b0};
            vecs[6] = '{2'd2, 32'h34, 32'h1, 32'h1, 32'hFFFF_FFFE, 0, PMAX, 32'hFFFF_FFFE, 1'b1};
            vecs[7] = '{2'd2, 32'h38, 32'h80, 32'hF0, 32'h8F, 0, 1, 32'h8F, 1'b0};
        end else begin
            vecs[5] = '{2'd2, 32'h30, 32'h1, 32'h1, 32'h3, 1, 0, 32'h0, 1'b1};
            vecs[6] = '{2'd2, 32'h34, 32'h1, 32'h1, 32'hFFFF_FFFE, 0, 0, 32'h0, 1'b1};
            vecs[7] = '{2'd2, 32'h38, 32'h80, 32'hF0, 32'h8F, 0, 0, 32'h0, 1'b1};
        end

        // Reset values
        tick(); tick();
        check("rst_bus_req", 64'(bus_req), 64'(0));
        check("rst_bus_we", 64'(bus_we), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_bus_addr", 64'(bus_addr), 64'(0));
        check("rst_bus_wdata", 64'(bus_wdata), 64'(0));
        check("rst_rsp_data", 64'(rsp_data), 64'(0));
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Poll that matches on the third read: req, gap, req, gap, req, rsp
        if (POLL_EN) begin
            cmd_valid = 1'b1; cmd_op = 2'd2; cmd_addr = 32'h40; cmd_wdata = 32'h1; cmd_mask = 32'h1;
            tick();
            cmd_valid = 1'b0;
            req_hist = '0; rsp_hist = '0; k = 0; cap_data = '0; cap_err = 1'b1;
            for (int cc = 0; cc < 8; cc++) begin
                req_hist[cc] = bus_req;
                rsp_hist[cc] = rsp_valid;
                if (rsp_valid) begin cap_data = rsp_data; cap_err = rsp_err; end
                if (bus_req) begin man_ack = 1'b1; man_rdata = (k < 2) ? 32'h0 : 32'h1; k++; end
                else man_ack = 1'b0;
                tick();
            end
            man_ack = 1'b0;
            check("poll3_req_pattern", 64'(req_hist), 64'(8'h2A));
            check("poll3_rsp_pattern", 64'(rsp_hist), 64'(8'h40));
            check("poll3_rsp_data", 64'(cap_data), 64'(1));
            check("poll3_rsp_err", 64'(cap_err), 64'(0));
        end

        // Reset during REQ with commands still queued
        for (int i = 0; i < 3; i++) push_cmd('{2'd1, AW'(32'h200 + i * 4), 32'h0, 32'h0});
        check("prerst_bus_req", 64'(bus_req), 64'(1));
        check("prerst_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check("midrst_bus_req", 64'(bus_req), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("midrst_bus_addr", 64'(bus_addr), 64'(0));
        tick(); tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int cc = 0; cc < 6; cc++) begin
            if (rsp_valid || bus_req || busy) seen = 1'b1;
            tick();
        end
        check("postrst_quiet", 64'(seen), 64'(0));
        cmd_q.delete();

        // Five back-to-back pushes with the bus stalled, then one rejected push
        bus_log.delete(); rsp_log.delete();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("b2b_ready%0d", i), 64'(cmd_ready), 64'(1));
            push_cmd('{2'(i % 2), AW'(32'h100 + i * 4), DW'(32'hC0DE_0000 + i), 32'h0});
        end
        check("b2b_full", 64'(cmd_ready), 64'(0));
        check("b2b_stalled_req", 64'(bus_req), 64'(1));
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 32'hBAD0; cmd_wdata = 32'hBAD;
        tick();
        check("b2b_still_full", 64'(cmd_ready), 64'(0));
        cmd_valid = 1'b0;
        auto_bus = 1'b1;
        drain();
        model_check();

        // Randomized traffic against the model
        bus_log.delete(); rsp_log.delete();
        for (int i = 0; i < 60; i++) begin
            c.op    = 2'($urandom_range(0, 3));
            c.addr  = AW'($urandom_range(0, 15) * 4);
            c.wdata = (c.op == 2'd2) ? DW'($urandom_range(0, 3)) : DW'($urandom);
            c.mask  = DW'($urandom_range(1, 3));
            repeat ($urandom_range(0, 2)) tick();
            push_cmd(c);
        end
        drain();
        model_check();
        auto_bus = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
